// File: rtl/huffman_tree_ctrl.sv
// Builds the 4-symbol Huffman node table from leaf weights.
// The leaf selector is held in reset until the table is final.
module huffman_tree_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [4:0]  w_A,
  input  logic [4:0]  w_B,
  input  logic [4:0]  w_C,
  input  logic [4:0]  w_D,
  output logic        busy,
  output logic        done,
  output logic        sel_nRST,
  output logic [12:0] info_node_1,
  output logic [12:0] info_node_2,
  output logic [12:0] info_node_3,
  output logic [12:0] info_node_4,
  output logic [12:0] info_node_5,
  output logic [12:0] info_node_6,
  output logic [12:0] info_node_7
);

  typedef enum logic [2:0] {IDLE, LOAD, PICK1, PICK2, MERGE, DONE} state_t;

  state_t      state, next_state;
  logic [1:0]  m;
  logic [12:0] node [1:7];
  logic [2:0]  min1, min2;
  logic [2:0]  pick;
  logic        found;
  logic [4:0]  best_w;
  logic [2:0]  new_slot;
  logic [3:0]  new_id;

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[5] ? 5'h1F : s[4:0];
  endfunction

  // Active = parent field still equals own id, and the slot has been written.
  always_comb begin
    pick   = 3'd1;
    found  = 1'b0;
    best_w = 5'd0;
    for (int i = 1; i <= 7; i++) begin
      if ((node[i][7:4] == node[i][3:0]) && (i <= 3 + int'(m)) &&
          !((state == PICK2) && (3'(i) == min1))) begin
        if (!found || (node[i][12:8] < best_w)) begin
          found  = 1'b1;
          best_w = node[i][12:8];
          pick   = 3'(i);
        end
      end
    end
  end

  assign new_slot = 3'd4 + {1'b0, m};
  assign new_id   = {2'b00, m};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = PICK1;
      PICK1:   next_state = PICK2;
      PICK2:   next_state = MERGE;
      MERGE:   next_state = (m == 2'd3) ? DONE : PICK1;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      m        <= 2'd1;
      min1     <= 3'd1;
      min2     <= 3'd1;
      sel_nRST <= 1'b0;
      for (int i = 1; i <= 7; i++) node[i] <= 13'd0;
    end else begin
      state <= next_state;
      case (state)
        LOAD: begin
          node[1]  <= {w_A, 4'hA, 4'hA};
          node[2]  <= {w_B, 4'hB, 4'hB};
          node[3]  <= {w_C, 4'hC, 4'hC};
          node[4]  <= {w_D, 4'hD, 4'hD};
          node[5]  <= 13'd0;
          node[6]  <= 13'd0;
          node[7]  <= 13'd0;
          m        <= 2'd1;
          sel_nRST <= 1'b0;
        end
        PICK1: min1 <= pick;
        PICK2: min2 <= pick;
        MERGE: begin
          node[new_slot]   <= {sat_add(node[min1][12:8], node[min2][12:8]), new_id, new_id};
          node[min1][7:4]  <= new_id;
          node[min2][7:4]  <= new_id;
          if (m != 2'd3) m <= m + 2'd1;
        end
        DONE: sel_nRST <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign info_node_1 = node[1];
  assign info_node_2 = node[2];
  assign info_node_3 = node[3];
  assign info_node_4 = node[4];
  assign info_node_5 = node[5];
  assign info_node_6 = node[6];
  assign info_node_7 = node[7];

endmodule

// File: tb/tb_huffman_tree_ctrl.sv
// Randomized bench for huffman_tree_ctrl against a behavioural Huffman model.
module tb_huffman_tree_ctrl;

  typedef logic [4:0]  wts_t [4];
  typedef logic [12:0] tbl_t [7];

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  w_A = '0, w_B = '0, w_C = '0, w_D = '0;
  logic        busy, done, sel_nRST;
  logic [12:0] info_node_1, info_node_2, info_node_3, info_node_4;
  logic [12:0] info_node_5, info_node_6, info_node_7;
  logic [12:0] obs [7];

  int n_checks = 0;
  int n_errors = 0;

  huffman_tree_ctrl dut (
    .CLK(CLK), .nRST(nRST), .start(start),
    .w_A(w_A), .w_B(w_B), .w_C(w_C), .w_D(w_D),
    .busy(busy), .done(done), .sel_nRST(sel_nRST),
    .info_node_1(info_node_1), .info_node_2(info_node_2), .info_node_3(info_node_3),
    .info_node_4(info_node_4), .info_node_5(info_node_5), .info_node_6(info_node_6),
    .info_node_7(info_node_7)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    obs[0] = info_node_1; obs[1] = info_node_2; obs[2] = info_node_3; obs[3] = info_node_4;
    obs[4] = info_node_5; obs[5] = info_node_6; obs[6] = info_node_7;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Huffman construction: repeatedly merge the two lightest parentless nodes.
  task automatic model(input wts_t w, output tbl_t t);
    int wt [7];
    int par [7];
    bit has_par [7];
    int ids [7];
    int a, b;
    ids = '{10, 11, 12, 13, 1, 2, 3};
    for (int i = 0; i < 7; i++) begin
      wt[i] = (i < 4) ? int'(w[i]) : 0;
      par[i] = 0;
      has_par[i] = 1'b0;
    end
    for (int r = 1; r <= 3; r++) begin
      a = -1;
      b = -1;
      for (int i = 0; i < 3 + r; i++)
        if (!has_par[i] && (a < 0 || wt[i] < wt[a])) a = i;
      for (int i = 0; i < 3 + r; i++)
        if (!has_par[i] && i != a && (b < 0 || wt[i] < wt[b])) b = i;
      wt[3 + r] = (wt[a] + wt[b] > 31) ? 31 : wt[a] + wt[b];
      has_par[a] = 1'b1; par[a] = r;
      has_par[b] = 1'b1; par[b] = r;
    end
    for (int i = 0; i < 7; i++)
      t[i] = {5'(wt[i]), has_par[i] ? 4'(par[i]) : 4'(ids[i]), 4'(ids[i])};
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_w(input wts_t w);
    w_A = w[0]; w_B = w[1]; w_C = w[2]; w_D = w[3];
  endtask

  task automatic set_noise();
    w_A = 5'($urandom); w_B = 5'($urandom); w_C = 5'($urandom); w_D = 5'($urandom);
  endtask

  task automatic run_build(input wts_t w, input bit extra_start, input bit noise);
    tbl_t exp_t;
    model(w, exp_t);
    for (int c = 0; c <= 12; c++) begin
      start = (c == 0) || (extra_start && (c == 3 || c == 11 || c == 12));
      if (c == 1) set_w(w);
      else if (noise) set_noise();
      check($sformatf("busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 11));
      check($sformatf("done c%0d", c), 32'(done), 32'(c == 11));
      if (c >= 2) check($sformatf("sel_nRST c%0d", c), 32'(sel_nRST), 32'(c >= 12));
      if (c == 11)
        for (int i = 0; i < 7; i++)
          check($sformatf("node%0d", i + 1), 32'(obs[i]), 32'(exp_t[i]));
      tick();
    end
    start = 1'b0;
    if (extra_start) begin
      for (int c = 13; c <= 24; c++) begin
        check($sformatf("rebuild busy c%0d", c), 32'(busy), 32'(c <= 23));
        check($sformatf("rebuild done c%0d", c), 32'(done), 32'(c == 23));
        tick();
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s node%0d", tag, i + 1), 32'(obs[i]), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " sel_nRST"}, 32'(sel_nRST), 32'd0);
  endtask

  initial begin
    wts_t w;
    tbl_t lit;

    nRST = 1'b0;
    tick(); tick();
    check_cleared("reset");
    nRST = 1'b1;
    tick();

    // Tie in merge 2 (C=3 vs n1=3) must choose C.
    w = '{5'd1, 5'd2, 5'd3, 5'd4};
    run_build(w, 1'b0, 1'b1);
    lit = '{13'h11A, 13'h21B, 13'h32C, 13'h43D, 13'h321, 13'h632, 13'hA33};
    for (int i = 0; i < 7; i++)
      check($sformatf("basic node%0d", i + 1), 32'(obs[i]), 32'(lit[i]));

    w = '{5'd4, 5'd4, 5'd4, 5'd4};
    run_build(w, 1'b0, 1'b0);
    lit = '{13'h41A, 13'h41B, 13'h42C, 13'h42D, 13'h831, 13'h832, 13'h1033};
    for (int i = 0; i < 7; i++)
      check($sformatf("eq4 node%0d", i + 1), 32'(obs[i]), 32'(lit[i]));

    w = '{5'd20, 5'd20, 5'd20, 5'd20};
    run_build(w, 1'b0, 1'b0);
    check("sat n1", 32'(obs[4][12:8]), 32'd31);
    check("sat n2", 32'(obs[5][12:8]), 32'd31);
    check("sat n3", 32'(obs[6][12:8]), 32'd31);

    w = '{5'd7, 5'd2, 5'd9, 5'd1};
    run_build(w, 1'b1, 1'b1);

    // Reset in cycle 6 of a build.
    start = 1'b1;
    set_w(w);
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 6) nRST = 1'b0;
      tick();
    end
    nRST = 1'b1;
    check_cleared("midreset");
    tick();
    check("midreset stays idle", 32'(busy), 32'd0);
    w = '{5'd3, 5'd1, 5'd4, 5'd1};
    run_build(w, 1'b0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      for (int j = 0; j < 4; j++) w[j] = 5'($urandom_range(0, 31));
      run_build(w, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
